pipe_scoreboard: RTL

Parametrised hazard and forwarding scoreboard for the in-order core pipeline, placed between the ID stage and the register files. It tracks every in-flight register write from the EX output latch to the WB output latch. It forwards the youngest available result to the two ID source operands, and requests a stall when a source depends on a result that is not yet produced. Depth, register count, data width and per-instruction result latency are all configurable, so load-use interlocks are handled by the same logic as ALU forwarding.

---
 rtl/pipe_scoreboard_pkg.sv | 23 ++
 rtl/pipe_scoreboard_lookup.sv | 40 ++++
 rtl/pipe_scoreboard.sv | 136 +++++++++++++
 3 files changed

// File: rtl/pipe_scoreboard_pkg.sv
// Shared defaults and helpers for the pipeline hazard/forwarding scoreboard.
package pipe_scoreboard_pkg;

    // Default geometry
    localparam int unsigned DEPTH_DEF  = 4;
    localparam int unsigned REGS_DEF   = 16;
    localparam int unsigned DATA_W_DEF = 24;
    localparam int unsigned CNT_W_DEF  = 16;

    // Index width that stays at least one bit for degenerate sizes
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Slot-entry field widths for the default geometry
    localparam int unsigned SLOT_DST_W_DEF = idx_w(REGS_DEF);
    localparam int unsigned SLOT_RDY_W_DEF = idx_w(DEPTH_DEF);

    // First slot whose stage result carries the value
    localparam int unsigned RDY_ALU  = 0;
    localparam int unsigned RDY_LOAD = 2;

endpackage

// File: rtl/pipe_scoreboard_lookup.sv
// Youngest-match priority search over the in-flight slots for one source operand.
module sb_lookup
    import pipe_scoreboard_pkg::*;
#(
    parameter int unsigned DEPTH  = DEPTH_DEF,
    parameter int unsigned REGS   = REGS_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    localparam int unsigned RW    = idx_w(REGS),
    localparam int unsigned RDW   = idx_w(DEPTH)
) (
    input  logic                      used_i,
    input  logic [RW-1:0]             src_i,
    input  logic [DEPTH-1:0]          slot_valid_i,
    input  logic [DEPTH-1:0]          slot_we_i,
    input  logic [DEPTH-1:0][RW-1:0]  slot_dst_i,
    input  logic [DEPTH-1:0][RDW-1:0] slot_rdy_i,
    input  logic [DEPTH*DATA_W-1:0]   stage_result_i,
    output logic                      hit_o,
    output logic                      pending_o,
    output logic [DATA_W-1:0]         value_o
);

    logic [RDW-1:0] sel;

    // Scan oldest to youngest so the lowest matching slot is the one that sticks
    always_comb begin
        hit_o = 1'b0;
        sel   = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (used_i && slot_valid_i[k] && slot_we_i[k] && (slot_dst_i[k] == src_i)) begin
                hit_o = 1'b1;
                sel   = RDW'(k);
            end
        end
        // Result not yet produced when the producer sits before its ready slot
        pending_o = hit_o && (sel < slot_rdy_i[sel]);
        value_o   = stage_result_i[sel*DATA_W +: DATA_W];
    end

endmodule

// File: rtl/pipe_scoreboard.sv
// Hazard and forwarding scoreboard between ID and the register files: tracks in-flight
// writes, forwards the youngest ready result and stalls on not-yet-produced results.
module pipe_scoreboard
    import pipe_scoreboard_pkg::*;
#(
    parameter int unsigned DEPTH  = DEPTH_DEF,
    parameter int unsigned REGS   = REGS_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF,
    localparam int unsigned RW    = idx_w(REGS),
    localparam int unsigned RDW   = idx_w(DEPTH)
) (
    input  logic                    iw_clk,
    input  logic                    iw_rst_n,
    input  logic                    iw_issue_valid,
    input  logic                    iw_issue_we,
    input  logic [RW-1:0]           iw_issue_dst,
    input  logic [RDW-1:0]          iw_issue_rdy,
    input  logic                    iw_flush,
    input  logic                    iw_src_a_used,
    input  logic                    iw_src_b_used,
    input  logic [RW-1:0]           iw_src_a,
    input  logic [RW-1:0]           iw_src_b,
    input  logic [DATA_W-1:0]       iw_rf_a,
    input  logic [DATA_W-1:0]       iw_rf_b,
    input  logic [DEPTH*DATA_W-1:0] iw_stage_result,
    output logic [DATA_W-1:0]       ow_src_a_val,
    output logic [DATA_W-1:0]       ow_src_b_val,
    output logic                    ow_stall,
    output logic                    ow_busy,
    output logic [CNT_W-1:0]        or_stall_cnt
);

    // Slot 0 is the EX/MA latch, slot DEPTH-1 retires into the register file
    logic [DEPTH-1:0]          slot_valid_q, slot_valid_d;
    logic [DEPTH-1:0]          slot_we_q, slot_we_d;
    logic [DEPTH-1:0][RW-1:0]  slot_dst_q, slot_dst_d;
    logic [DEPTH-1:0][RDW-1:0] slot_rdy_q, slot_rdy_d;
    logic [CNT_W-1:0]          stall_cnt_q, stall_cnt_d;

    logic              hit_a, hit_b;
    logic              pend_a, pend_b;
    logic [DATA_W-1:0] fwd_a, fwd_b;
    logic              stall;
    logic              issue_fire;

    sb_lookup #(
        .DEPTH  (DEPTH),
        .REGS   (REGS),
        .DATA_W (DATA_W)
    ) u_lookup_a (
        .used_i         (iw_src_a_used),
        .src_i          (iw_src_a),
        .slot_valid_i   (slot_valid_q),
        .slot_we_i      (slot_we_q),
        .slot_dst_i     (slot_dst_q),
        .slot_rdy_i     (slot_rdy_q),
        .stage_result_i (iw_stage_result),
        .hit_o          (hit_a),
        .pending_o      (pend_a),
        .value_o        (fwd_a)
    );

    sb_lookup #(
        .DEPTH  (DEPTH),
        .REGS   (REGS),
        .DATA_W (DATA_W)
    ) u_lookup_b (
        .used_i         (iw_src_b_used),
        .src_i          (iw_src_b),
        .slot_valid_i   (slot_valid_q),
        .slot_we_i      (slot_we_q),
        .slot_dst_i     (slot_dst_q),
        .slot_rdy_i     (slot_rdy_q),
        .stage_result_i (iw_stage_result),
        .hit_o          (hit_b),
        .pending_o      (pend_b),
        .value_o        (fwd_b)
    );

    // Operand resolution and stall decision; a flush squashes both stall and issue
    always_comb begin
        ow_src_a_val = (hit_a && !pend_a) ? fwd_a : iw_rf_a;
        ow_src_b_val = (hit_b && !pend_b) ? fwd_b : iw_rf_b;
        stall        = iw_issue_valid && !iw_flush && (pend_a || pend_b);
        issue_fire   = iw_issue_valid && !iw_flush && !stall;
    end

    assign ow_stall     = stall;
    assign ow_busy      = |slot_valid_q;
    assign or_stall_cnt = stall_cnt_q;

    // Next slot state: shift toward retirement, ID instruction or a bubble enters slot 0
    always_comb begin
        slot_valid_d = '0;
        slot_we_d    = '0;
        slot_dst_d   = '0;
        slot_rdy_d   = '0;
        for (int k = 1; k < DEPTH; k++) begin
            slot_valid_d[k] = slot_valid_q[k-1];
            slot_we_d[k]    = slot_we_q[k-1];
            slot_dst_d[k]   = slot_dst_q[k-1];
            slot_rdy_d[k]   = slot_rdy_q[k-1];
        end
        slot_valid_d[0] = issue_fire;
        slot_we_d[0]    = iw_issue_we;
        slot_dst_d[0]   = iw_issue_dst;
        slot_rdy_d[0]   = iw_issue_rdy;
    end

    // Saturating stall-cycle counter
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // Slot and counter state
    always_ff @(posedge iw_clk or negedge iw_rst_n) begin
        if (!iw_rst_n) begin
            slot_valid_q <= '0;
            slot_we_q    <= '0;
            slot_dst_q   <= '0;
            slot_rdy_q   <= '0;
            stall_cnt_q  <= '0;
        end else begin
            slot_valid_q <= slot_valid_d;
            slot_we_q    <= slot_we_d;
            slot_dst_q   <= slot_dst_d;
            slot_rdy_q   <= slot_rdy_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

endmodule
